// File: rtl/gray_sync_decoder.sv
// Gray-code receive side: synchronizes an async Gray count, decodes it to
// binary, and reports per-sample step, wrap and illegal multi-bit changes.
module gray_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] G,
  input  logic             err_clr,
  output logic [WIDTH-1:0] B,
  output logic             valid,
  output logic [WIDTH-1:0] step,
  output logic             wrap,
  output logic             err
);

  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] FILL = CW'(SYNC_STAGES);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] gsync;
  logic [WIDTH-1:0] bnew;
  logic [WIDTH-1:0] gdiff;
  logic             multi;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] gprev_q, gprev_d;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain; nothing combinational between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= G;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign gsync = sync_q[SYNC_STAGES-1];
  assign bnew  = gray2bin(gsync);
  assign gdiff = gsync ^ gprev_q;
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign multi = (gdiff & (gdiff - 1'b1)) != '0;

  // Next state: fill counter, decode load, step/wrap/err evaluation.
  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    b_d     = b_q;
    step_d  = '0;
    wrap_d  = 1'b0;
    err_d   = err_q & ~err_clr;
    gprev_d = gprev_q;
    if (!valid_q) begin
      if (cnt_q == FILL) begin
        valid_d = 1'b1;
        b_d     = bnew;
        gprev_d = gsync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      b_d     = bnew;
      gprev_d = gsync;
      step_d  = bnew - b_q;
      wrap_d  = (b_q == {WIDTH{1'b1}}) && (bnew == '0);
      if (multi) begin
        err_d = 1'b1;
      end
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      b_q     <= '0;
      step_q  <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      gprev_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      b_q     <= b_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      gprev_q <= gprev_d;
    end
  end

  assign B     = b_q;
  assign valid = valid_q;
  assign step  = step_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Scoreboard bench for gray_sync_decoder at WIDTH=4, SYNC_STAGES=2.
// Expected output tuples are queued at drive time and popped at sample time.
module tb_gray_sync_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] G = 4'd0;
  logic [3:0] B;
  logic       valid;
  logic [3:0] step;
  logic       wrap;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       v;
    logic [3:0] b;
    logic [3:0] s;
    logic       w;
    logic       e;
  } exp_t;

  exp_t sbq[$];

  gray_sync_decoder #(
    .WIDTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .G(G),
    .err_clr(err_clr),
    .B(B),
    .valid(valid),
    .step(step),
    .wrap(wrap),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(logic v, int b, int s, logic w, logic e);
    return exp_t'({v, 4'(b), 4'(s), w, e});
  endfunction

  function automatic exp_t obs();
    return exp_t'({valid, B, step, wrap, err});
  endfunction

  function automatic logic [3:0] gray(int i);
    return 4'(i ^ (i >> 1));
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t o;
    rst_n = 1'b0;
    G = 4'b0110;
    cyc(3);
    sbq.push_back(mk(0, 0, 0, 0, 0));
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_hold got %p expected %p", o, e);
    end
    rst_n = 1'b1;
    sbq.push_back(mk(0, 0, 0, 0, 0));
    sbq.push_back(mk(1, 4, 0, 0, 0));
    cyc(2);
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL pre_valid got %p expected %p", o, e);
    end
    cyc(1);
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL first_valid got %p expected %p", o, e);
    end
  endtask

  task automatic test_full_count();
    exp_t e;
    exp_t o;
    rst_n = 1'b0;
    G = 4'd0;
    cyc(1);
    rst_n = 1'b1;
    sbq.push_back(mk(1, 0, 0, 0, 0));
    cyc(3);
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL count_start got %p expected %p", o, e);
    end
    for (int i = 1; i < 16; i++) begin
      G = gray(i);
      sbq.push_back(mk(1, i - 1, 0, 0, 0));
      sbq.push_back(mk(1, i, 1, 0, 0));
      sbq.push_back(mk(1, i, 0, 0, 0));
      cyc(2);
      e = sbq.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL count_hold[%0d] got %p expected %p", i, o, e);
      end
      cyc(1);
      e = sbq.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL count_update[%0d] got %p expected %p", i, o, e);
      end
      cyc(1);
      e = sbq.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL count_settle[%0d] got %p expected %p", i, o, e);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    exp_t o;
    G = 4'b0000;
    sbq.push_back(mk(1, 15, 0, 0, 0));
    sbq.push_back(mk(1, 0, 1, 1, 0));
    sbq.push_back(mk(1, 0, 0, 0, 0));
    cyc(2);
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL wrap_before got %p expected %p", o, e);
    end
    cyc(1);
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL wrap_pulse got %p expected %p", o, e);
    end
    cyc(1);
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL wrap_end got %p expected %p", o, e);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    exp_t o;
    G = 4'b0011;
    sbq.push_back(mk(1, 2, 2, 0, 1));
    cyc(3);
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL illegal_jump got %p expected %p", o, e);
    end
    cyc(1);
    G = 4'b0010;
    sbq.push_back(mk(1, 3, 1, 0, 1));
    sbq.push_back(mk(1, 3, 0, 0, 1));
    cyc(3);
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL err_sticky got %p expected %p", o, e);
    end
    cyc(1);
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL err_sticky_hold got %p expected %p", o, e);
    end
  endtask

  task automatic test_err_clr();
    exp_t e;
    exp_t o;
    err_clr = 1'b1;
    sbq.push_back(mk(1, 3, 0, 0, 0));
    cyc(1);
    err_clr = 1'b0;
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL clr_alone got %p expected %p", o, e);
    end
    G = 4'b0001;
    sbq.push_back(mk(1, 1, 14, 0, 1));
    sbq.push_back(mk(1, 1, 0, 0, 1));
    cyc(2);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL clr_vs_err got %p expected %p", o, e);
    end
    cyc(1);
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL clr_vs_err_hold got %p expected %p", o, e);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    exp_t o;
    G = 4'b1101;
    sbq.push_back(mk(1, 9, 8, 0, 1));
    cyc(3);
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL pre_reset_b9 got %p expected %p", o, e);
    end
    #2;
    rst_n = 1'b0;
    sbq.push_back(mk(0, 0, 0, 0, 0));
    #1;
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL async_reset got %p expected %p", o, e);
    end
    cyc(1);
    rst_n = 1'b1;
    sbq.push_back(mk(0, 0, 0, 0, 0));
    sbq.push_back(mk(1, 9, 0, 0, 0));
    cyc(2);
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL relatency_pre got %p expected %p", o, e);
    end
    cyc(1);
    e = sbq.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL relatency_valid got %p expected %p", o, e);
    end
  endtask

  initial begin
    test_reset();
    test_full_count();
    test_wrap();
    test_illegal();
    test_err_clr();
    test_async_reset();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
